load_store_unit: RTL and testbench

Multi-cycle load/store unit between the CPU datapath (ALU address, rs2 store data, funct3) and a word-organised data memory with a request/acknowledge handshake. It converts LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses with byte enables. It performs byte-lane steering and sign/zero extension, detects misaligned and illegal accesses, and bounds memory wait time with a timeout. While an access is in flight it stalls the CPU so PC and register write-back hold.

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word accesses into word-wide memory
// requests with byte enables, lane steering, extension and a bounded wait.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    output logic        cpu_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

    logic        dec_legal;
    logic        dec_misaligned;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    // Pick the addressed lane out of the read word and extend it to 32 bits.
    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  format_load = {{24{b[7]}}, b};
            3'b100:  format_load = {24'b0, b};
            3'b001:  format_load = {{16{h[15]}}, h};
            3'b101:  format_load = {16'b0, h};
            3'b010:  format_load = word;
            default: format_load = 32'b0;
        endcase
    endfunction

    always_comb begin
        dec_legal      = 1'b0;
        dec_misaligned = 1'b0;
        dec_be         = 4'b1111;
        dec_wdata      = 32'b0;
        if (cpu_write) begin
            case (cpu_funct3)
                3'b000: begin
                    dec_legal = 1'b1;
                    dec_be    = 4'b0001 << cpu_addr[1:0];
                    dec_wdata = {4{cpu_wdata[7:0]}};
                end
                3'b001: begin
                    dec_legal      = 1'b1;
                    dec_misaligned = cpu_addr[0];
                    dec_be         = cpu_addr[1] ? 4'b1100 : 4'b0011;
                    dec_wdata      = {2{cpu_wdata[15:0]}};
                end
                3'b010: begin
                    dec_legal      = 1'b1;
                    dec_misaligned = |cpu_addr[1:0];
                    dec_wdata      = cpu_wdata;
                end
                default: ;
            endcase
        end else begin
            case (cpu_funct3)
                3'b000, 3'b100: dec_legal = 1'b1;
                3'b001, 3'b101: begin
                    dec_legal      = 1'b1;
                    dec_misaligned = cpu_addr[0];
                end
                3'b010: begin
                    dec_legal      = 1'b1;
                    dec_misaligned = |cpu_addr[1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        fault_d  = fault_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        case (state_q)
            IDLE: begin
                if (cpu_valid) begin
                    if (dec_legal && !dec_misaligned) begin
                        state_d  = ACCESS;
                        req_d    = 1'b1;
                        we_d     = cpu_write;
                        addr_d   = cpu_addr[31:2];
                        be_d     = dec_be;
                        wdata_d  = dec_wdata;
                        funct3_d = cpu_funct3;
                        off_d    = cpu_addr[1:0];
                        cnt_d    = 8'd0;
                    end else begin
                        // Decode faults never touch memory.
                        state_d = RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        rdata_d = 32'b0;
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    fault_d = 1'b0;
                    rdata_d = we_q ? 32'b0 : format_load(funct3_q, off_q, mem_rdata);
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q == LAST_WAIT) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    fault_d = 1'b1;
                    rdata_d = 32'b0;
                    req_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            rdata_q <= 32'b0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 30'b0;
            wdata_q <= 32'b0;
            be_q    <= 4'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // Access shape is only consulted while in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        funct3_q <= funct3_d;
        off_q    <= off_d;
    end

    assign cpu_stall = cpu_valid & ~done_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;
    assign cpu_fault = fault_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, randomized accesses against a
// reference model, plus timeout, late-ack and reset-mid-access sequences.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_write;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_fault;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic [31:0] mem [16];

    int tests = 0;
    int fails = 0;

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_write(cpu_write), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_fault(cpu_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] word;
        int          waits;
        logic [31:0] rdata;
        logic        fault;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Reference model written from the access rules.
    function automatic bit ref_legal(input bit wr, input int f3);
        if (wr) return f3 <= 2;
        return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
    endfunction

    function automatic bit ref_misal(input int f3, input int off);
        int sz = f3 % 4;
        return (sz == 1 && off % 2 == 1) || (sz == 2 && off != 0);
    endfunction

    function automatic logic [31:0] ref_load(input int f3, input int off, input logic [31:0] word);
        longint unsigned w = longint'(word);
        int b = int'((w >> (8 * off)) % 256);
        int h = int'((w >> (16 * (off / 2))) % 65536);
        case (f3)
            0: return (b >= 128) ? 32'(b - 256) : 32'(b);
            4: return 32'(b);
            1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            5: return 32'(h);
            2: return word;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input bit wr, input int f3, input int off);
        if (!wr) return 4'hF;
        if (f3 == 0) return 4'(1 << off);
        if (f3 == 1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_mwd(input bit wr, input int f3, input logic [31:0] wd);
        if (!wr) return 32'h0;
        if (f3 == 0) return (wd % 256) * 32'h01010101;
        if (f3 == 1) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // Runs one access from IDLE, acting as the memory; returns in IDLE.
    task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, input int waits,
                              output logic [31:0] o_rdata, output logic o_fault,
                              output int o_lat, output int o_req,
                              output logic [3:0] o_be, output logic o_we,
                              output logic [29:0] o_maddr, output logic [31:0] o_mwd,
                              output logic o_stall_ok, output logic o_bound_hit);
        bit done = 0;
        o_rdata = 'x; o_fault = 'x; o_lat = -1; o_req = 0;
        o_be = 'x; o_we = 'x; o_maddr = 'x; o_mwd = 'x; o_stall_ok = 1;
        cpu_valid = 1; cpu_write = wr; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (cpu_done) begin
                o_lat = c; o_rdata = cpu_rdata; o_fault = cpu_fault;
                if (cpu_stall !== 1'b0) o_stall_ok = 0;
                mem_ack = 0;
                done = 1;
                break;
            end
            if (cpu_stall !== 1'b1) o_stall_ok = 0;
            if (mem_req) begin
                o_req++;
                o_be = mem_be; o_we = mem_we; o_maddr = mem_addr; o_mwd = mem_wdata;
                if (o_req > waits) begin
                    mem_ack = 1;
                    mem_rdata = mem[mem_addr[3:0]];
                    if (mem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_be[k]) mem[mem_addr[3:0]][8*k +: 8] = mem_wdata[8*k +: 8];
                    end
                end else begin
                    mem_ack = 0;
                    mem_rdata = $urandom;
                end
            end else begin
                mem_ack = 0;
            end
        end
        o_bound_hit = !done;
        cpu_valid = 0;
        mem_ack = 0;
        @(negedge clk);
    endtask

    task automatic check_access(input string tag, input vec_t v);
        logic [31:0] rd, mwd;
        logic flt, we, stall_ok, bound_hit;
        logic [3:0] be;
        logic [29:0] maddr;
        int lat, req, exp_lat, exp_req, off, f3;
        bit decf;
        off = int'(v.addr[1:0]);
        f3 = int'(v.f3);
        mem[v.addr[5:2]] = v.word;
        run_access(v.wr, v.f3, v.addr, v.wd, v.waits, rd, flt, lat, req, be, we, maddr, mwd,
                   stall_ok, bound_hit);
        decf = !ref_legal(v.wr, f3) || ref_misal(f3, off);
        if (decf) begin exp_lat = 1; exp_req = 0; end
        else if (v.waits < T) begin exp_lat = 2 + v.waits; exp_req = v.waits + 1; end
        else begin exp_lat = T + 1; exp_req = T; end
        check({tag, "_bound"}, 32'(bound_hit), 32'd0);
        check({tag, "_rdata"}, rd, v.rdata);
        check({tag, "_fault"}, 32'(flt), 32'(v.fault));
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_reqcycles"}, 32'(req), 32'(exp_req));
        check({tag, "_stall"}, 32'(stall_ok), 32'd1);
        if (exp_req > 0) begin
            check({tag, "_be"}, 32'(be), 32'(v.be));
            check({tag, "_we"}, 32'(we), 32'(v.wr));
            check({tag, "_maddr"}, 32'(maddr), 32'(v.addr[31:2]));
            check({tag, "_mwdata"}, mwd, v.mwd);
        end
    endtask

    initial begin
        vec_t v;
        // wr, f3, addr, wdata, mem word, waits, rdata, fault, be, mem_wdata
        tbl[0]  = '{1'b0, 3'b010, 32'h08, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0};
        tbl[1]  = '{1'b0, 3'b000, 32'h03, 32'h0,        32'h80FF1234, 0, 32'hFFFFFF80, 1'b0, 4'hF, 32'h0};
        tbl[2]  = '{1'b0, 3'b100, 32'h03, 32'h0,        32'h80FF1234, 1, 32'h00000080, 1'b0, 4'hF, 32'h0};
        tbl[3]  = '{1'b0, 3'b001, 32'h02, 32'h0,        32'h80FF1234, 0, 32'hFFFF80FF, 1'b0, 4'hF, 32'h0};
        tbl[4]  = '{1'b1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0,        0, 32'h0,        1'b0, 4'hC, 32'hABCDABCD};
        tbl[5]  = '{1'b0, 3'b010, 32'h05, 32'h0,        32'h0,        0, 32'h0,        1'b1, 4'hF, 32'h0};
        tbl[6]  = '{1'b1, 3'b011, 32'h00, 32'h55,       32'h0,        0, 32'h0,        1'b1, 4'hF, 32'h0};
        tbl[7]  = '{1'b0, 3'b101, 32'h02, 32'h0,        32'h80FF1234, 2, 32'h000080FF, 1'b0, 4'hF, 32'h0};
        tbl[8]  = '{1'b1, 3'b000, 32'h01, 32'h000000A5, 32'h0,        0, 32'h0,        1'b0, 4'h2, 32'hA5A5A5A5};
        tbl[9]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h01020304, 3, 32'h01020304, 1'b0, 4'hF, 32'h0};
        tbl[10] = '{1'b0, 3'b010, 32'h14, 32'h0,        32'h01020304, 4, 32'h0,        1'b1, 4'hF, 32'h0};
        tbl[11] = '{1'b0, 3'b000, 32'h00, 32'h0,        32'h0000007F, 0, 32'h0000007F, 1'b0, 4'hF, 32'h0};

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        reset = 1; cpu_valid = 0; cpu_write = 0; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(cpu_done), 32'd0);
        check("rst_fault", 32'(cpu_fault), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_be", 32'(mem_be), 32'd0);
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) check_access($sformatf("vec%0d", i), tbl[i]);

        // Timeout then a late ack while idle: it must be ignored.
        check_access("tmo", tbl[10]);
        begin
            bit quiet = 1;
            mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
            repeat (3) begin
                @(negedge clk);
                if (mem_req !== 1'b0 || cpu_done !== 1'b0) quiet = 0;
            end
            mem_ack = 0;
            check("late_ack_ignored", 32'(quiet), 32'd1);
        end
        check_access("after_tmo", tbl[0]);

        // Reset during the second ACCESS cycle of a waited load.
        mem[0] = 32'hCAFEF00D;
        cpu_valid = 1; cpu_write = 0; cpu_funct3 = 3'b010; cpu_addr = 32'h0; cpu_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        check("rstmid_req_before", 32'(mem_req), 32'd1);
        reset = 1;
        @(negedge clk);
        check("rstmid_req", 32'(mem_req), 32'd0);
        check("rstmid_done", 32'(cpu_done), 32'd0);
        check("rstmid_outs", {cpu_rdata | mem_wdata}, 32'd0);
        check("rstmid_ctl", 32'({cpu_fault, mem_we, mem_be, mem_addr != 30'd0}), 32'd0);
        reset = 0; cpu_valid = 0;
        begin
            bit no_done = 1;
            repeat (4) begin
                @(negedge clk);
                if (cpu_done !== 1'b0 || mem_req !== 1'b0) no_done = 0;
            end
            check("rstmid_no_done", 32'(no_done), 32'd1);
        end
        v = '{1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 4'hF, 32'h0};
        check_access("after_rst", v);

        // Randomized accesses against the model.
        for (int i = 0; i < 80; i++) begin
            int f3, off;
            bit decf;
            v.wr = 1'($urandom_range(0, 1));
            v.f3 = 3'($urandom_range(0, 7));
            v.addr = 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_FFC0 & 32'h0);
            v.wd = $urandom;
            v.word = $urandom;
            v.waits = $urandom_range(0, 5);
            f3 = int'(v.f3);
            off = int'(v.addr[1:0]);
            decf = !ref_legal(v.wr, f3) || ref_misal(f3, off);
            v.fault = decf || (v.waits >= T);
            v.rdata = (v.fault || v.wr) ? 32'h0 : ref_load(f3, off, v.word);
            v.be = ref_be(v.wr, f3, off);
            v.mwd = ref_mwd(v.wr, f3, v.wd);
            check_access($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
